// File: rtl/cpu_bus_arbiter.sv
`timescale 1ns/10ps
`default_nettype none
// ============================================================================
// Module      : cpu_bus_arbiter
// Description : Round-robin arbiter for the CPU bus port with a grant-hold
//               watchdog whose ns limit is converted to cycles at elaboration.
// Revision    : 1.0  initial release
// ============================================================================
module cpu_bus_arbiter #(
    parameter int N_REQ         = 4,
    parameter int CLK_PERIOD_PS = 10000,
    parameter int TIMEOUT_NS    = 1000,
    localparam int IDW          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   gnt_id,
    output logic             busy,
    output logic             timeout_err,
    output logic [IDW-1:0]   timeout_id
);

    localparam int c_TIMEOUT_RAW = (TIMEOUT_NS * 1000 + CLK_PERIOD_PS - 1) / CLK_PERIOD_PS;
    localparam int c_TIMEOUT_CYC = (c_TIMEOUT_RAW < 1) ? 1 : c_TIMEOUT_RAW;
    localparam int c_CW          = (c_TIMEOUT_CYC > 1) ? $clog2(c_TIMEOUT_CYC + 1) : 1;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_GRANT   = 2'd1;
    localparam logic [1:0] c_ST_RELEASE = 2'd2;

    logic [1:0]       r_state;
    logic [N_REQ-1:0] r_gnt;
    logic [IDW-1:0]   r_gnt_id;
    logic [IDW-1:0]   r_rr_ptr;
    logic [c_CW-1:0]  r_cnt;
    logic             r_timeout_err;
    logic [IDW-1:0]   r_timeout_id;

    logic             w_found;
    logic [IDW-1:0]   w_sel_id;
    logic [N_REQ-1:0] w_sel_onehot;
    logic             w_owner_done;
    logic             w_owner_req;
    logic             w_at_limit;
    logic             w_exit;
    logic [IDW-1:0]   w_next_ptr;

    // First active request at or after the round-robin pointer, wrapping.
    always_comb begin
        w_found      = 1'b0;
        w_sel_id     = '0;
        w_sel_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && req[(int'(r_rr_ptr) + i) % N_REQ]) begin
                w_found  = 1'b1;
                w_sel_id = IDW'((int'(r_rr_ptr) + i) % N_REQ);
                w_sel_onehot[(int'(r_rr_ptr) + i) % N_REQ] = 1'b1;
            end
        end
    end

    assign w_owner_done = done[r_gnt_id];
    assign w_owner_req  = req[r_gnt_id];
    assign w_at_limit   = (r_cnt == c_CW'(c_TIMEOUT_CYC - 1));
    assign w_exit       = w_owner_done || !w_owner_req || w_at_limit;
    assign w_next_ptr   = (r_gnt_id == IDW'(N_REQ - 1)) ? '0 : r_gnt_id + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_gnt         <= '0;
            r_gnt_id      <= '0;
            r_rr_ptr      <= '0;
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
            r_timeout_id  <= '0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                c_ST_IDLE, c_ST_RELEASE: begin
                    if (w_found) begin
                        r_gnt    <= w_sel_onehot;
                        r_gnt_id <= w_sel_id;
                        r_cnt    <= '0;
                        r_state  <= c_ST_GRANT;
                    end else begin
                        r_state  <= c_ST_IDLE;
                    end
                end
                c_ST_GRANT: begin
                    if (w_exit) begin
                        r_gnt    <= '0;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= c_ST_RELEASE;
                        // An owner finishing on the last allowed cycle is not a timeout.
                        if (w_at_limit && !w_owner_done) begin
                            r_timeout_err <= 1'b1;
                            r_timeout_id  <= r_gnt_id;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign gnt_id      = r_gnt_id;
    assign busy        = |r_gnt;
    assign timeout_err = r_timeout_err;
    assign timeout_id  = r_timeout_id;

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_arbiter.sv
`timescale 1ns/10ps
`default_nettype none
// ============================================================================
// Module      : tb_cpu_bus_arbiter
// Description : Directed-vector bench for cpu_bus_arbiter at default parameters.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout_err;
    logic [1:0] timeout_id;

    int n_vec  = 0;
    int n_miss = 0;

    cpu_bus_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .gnt         (gnt),
        .gnt_id      (gnt_id),
        .busy        (busy),
        .timeout_err (timeout_err),
        .timeout_id  (timeout_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then stable for sampling and inputs may change.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 4'b0000;
        done = 4'b0000;
        tick();
        tick();
        rst  = 1'b0;
    endtask

    initial begin
        int cnt;
        int exp_id;

        // Reset state
        do_reset();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_gnt_id", 32'(gnt_id), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_terr", 32'(timeout_err), 32'h0);
        chk("rst_tid", 32'(timeout_id), 32'h0);

        // Single requester, done ends the grant
        req = 4'b0100;
        tick();
        chk("t1_gnt", 32'(gnt), 32'h4);
        chk("t1_gnt_id", 32'(gnt_id), 32'h2);
        chk("t1_busy", 32'(busy), 32'h1);
        tick(); tick(); tick(); tick();
        done = 4'b0100;
        chk("t1_hold", 32'(gnt), 32'h4);
        tick();
        done = 4'b0000;
        chk("t1_rel_gnt", 32'(gnt), 32'h0);
        chk("t1_rel_busy", 32'(busy), 32'h0);
        chk("t1_rel_terr", 32'(timeout_err), 32'h0);
        chk("t1_keep_id", 32'(gnt_id), 32'h2);

        // Round robin with all requesting, one idle cycle between grants
        do_reset();
        req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            exp_id = k % 4;
            chk("t2_gnt", 32'(gnt), 32'(4'b0001 << exp_id));
            chk("t2_id", 32'(gnt_id), 32'(exp_id));
            tick(); tick(); tick();
            done = 4'b0001 << exp_id;
            tick();
            done = 4'b0000;
            chk("t2_gap", 32'(gnt), 32'h0);
            tick();
        end

        // Watchdog: req[1] held for the full window, req[2] waiting behind it
        do_reset();
        req = 4'b0110;
        tick();
        chk("t3_gnt", 32'(gnt), 32'h2);
        cnt = 0;
        while (gnt == 4'b0010 && cnt < 200) begin
            if (timeout_err !== 1'b0) chk("t3_early_terr", 32'(timeout_err), 32'h0);
            cnt++;
            tick();
        end
        chk("t3_hold_cycles", 32'(cnt), 32'd100);
        chk("t3_rel_gnt", 32'(gnt), 32'h0);
        chk("t3_terr", 32'(timeout_err), 32'h1);
        chk("t3_tid", 32'(timeout_id), 32'h1);
        tick();
        chk("t3_next_gnt", 32'(gnt), 32'h4);
        chk("t3_terr_pulse", 32'(timeout_err), 32'h0);
        chk("t3_tid_held", 32'(timeout_id), 32'h1);
        req = 4'b0000;
        tick();
        chk("t3_req_drop", 32'(gnt), 32'h0);

        // done on the last allowed cycle wins over the watchdog
        do_reset();
        req = 4'b0001;
        tick();
        for (int i = 0; i < 99; i++) tick();
        chk("t4_still_gnt", 32'(gnt), 32'h1);
        done = 4'b0001;
        tick();
        done = 4'b0000;
        chk("t4_rel_gnt", 32'(gnt), 32'h0);
        chk("t4_no_terr", 32'(timeout_err), 32'h0);

        // Reset mid-grant, then pointer starts at 0 again
        do_reset();
        req = 4'b1000;
        tick();
        chk("t5_gnt", 32'(gnt), 32'h8);
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("t5_rst_gnt", 32'(gnt), 32'h0);
        chk("t5_rst_id", 32'(gnt_id), 32'h0);
        chk("t5_rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        req = 4'b1001;
        tick();
        chk("t5_first", 32'(gnt), 32'h1);

        // done from a non-owner is ignored
        do_reset();
        req = 4'b0010;
        tick();
        tick();
        done = 4'b0001;
        tick();
        done = 4'b0000;
        chk("t6_ignore", 32'(gnt), 32'h2);
        tick();
        chk("t6_ignore2", 32'(gnt), 32'h2);
        done = 4'b0010;
        tick();
        done = 4'b0000;
        chk("t6_rel", 32'(gnt), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
